// File: rtl/popcount_arbiter.sv
// Round-robin arbiter sharing one popcount engine among N requesters.
// Define POPCOUNT_ARB_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT cycles (rsp_err=1).
module popcount_arbiter #(
    parameter int N       = 4,
    parameter int W       = 30,
    parameter int CW      = $clog2(W + 1),
    parameter int TIMEOUT = W + 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] req_data,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   rsp_valid,
    output logic [CW-1:0]  rsp_count,
    output logic           rsp_err,
    output logic           busy,
    output logic           eng_start,
    output logic [W-1:0]   eng_data,
    input  logic           eng_dor,
    input  logic [CW-1:0]  eng_count
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [N-1:0]    rsp_valid_q, rsp_valid_d;
    logic [CW-1:0]   rsp_count_q, rsp_count_d;
    logic            busy_q, busy_d;
    logic            eng_start_q, eng_start_d;
    logic [W-1:0]    eng_data_q, eng_data_d;
    logic [PW-1:0]   winner;
    logic [PW-1:0]   next_ptr;
    logic            timed_out;

    // First requester at or after p, wrapping N-1 -> 0 (N need not be a power of 2).
    function automatic logic [PW-1:0] pick(input logic [N-1:0] r, input logic [PW-1:0] p);
        logic [PW-1:0] sel;
        logic          found;
        int            idx;
        sel   = p;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(p) + k;
            if (idx >= N) idx = idx - N;
            if (!found && r[PW'(idx)]) begin
                sel   = PW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [PW-1:0] i);
        return {{(N-1){1'b0}}, 1'b1} << i;
    endfunction

    assign winner   = pick(req, ptr_q);
    assign next_ptr = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;

`ifdef POPCOUNT_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          rsp_err_q, rsp_err_d;

    // Counts WAIT cycles without a done; cleared in every other state.
    always_comb begin
        wait_cnt_d = '0;
        if (state_q == WAIT && !eng_dor) wait_cnt_d = wait_cnt_q + 1'b1;
    end

    assign timed_out = (state_q == WAIT) && !eng_dor && (wait_cnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        rsp_err_d = rsp_err_q;
        if (state_q == WAIT) begin
            if (eng_dor)        rsp_err_d = 1'b0;
            else if (timed_out) rsp_err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign timed_out = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_count_d = rsp_count_q;
        eng_start_d = 1'b0;
        eng_data_d  = eng_data_q;

        unique case (state_q)
            IDLE: begin
                if (req != '0) begin
                    owner_d     = winner;
                    gnt_d       = onehot(winner);
                    eng_data_d  = req_data[int'(winner)*W +: W];
                    eng_start_d = 1'b1;
                    state_d     = LAUNCH;
                end
            end
            LAUNCH: state_d = WAIT;
            WAIT: begin
                if (eng_dor) begin
                    rsp_count_d = eng_count;
                    rsp_valid_d = onehot(owner_q);
                    ptr_d       = next_ptr;
                    state_d     = DRAIN;
                end else if (timed_out) begin
                    rsp_count_d = '0;
                    rsp_valid_d = onehot(owner_q);
                    ptr_d       = next_ptr;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                // A done held for several cycles (or arriving late) is absorbed here.
                if (!eng_dor) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_count_q <= '0;
            busy_q      <= 1'b0;
            eng_start_q <= 1'b0;
            eng_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_count_q <= rsp_count_d;
            busy_q      <= busy_d;
            eng_start_q <= eng_start_d;
            eng_data_q  <= eng_data_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_count = rsp_count_q;
    assign busy      = busy_q;
    assign eng_start = eng_start_q;
    assign eng_data  = eng_data_q;

endmodule

// File: tb/tb_popcount_arbiter.sv
// Directed bench for popcount_arbiter (N=4, W=8) with a simple delayed-done engine model.
// Builds with or without POPCOUNT_ARB_TIMEOUT_EN; the timeout scenario adapts to the build.
module tb_popcount_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [CW-1:0]  rsp_count;
    logic           rsp_err;
    logic           busy;
    logic           eng_start;
    logic [W-1:0]   eng_data;
    logic           eng_dor = 1'b0;
    logic [CW-1:0]  eng_count = '0;

    int checks = 0;
    int errors = 0;

    int eng_delay = 3;
    int eng_hold  = 2;
    bit eng_dead  = 1'b0;
    int e_cnt     = 0;
    int e_hold    = 0;

    popcount_arbiter #(.N(N), .W(W), .CW(CW), .TIMEOUT(12)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_count (rsp_count),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .eng_start (eng_start),
        .eng_data  (eng_data),
        .eng_dor   (eng_dor),
        .eng_count (eng_count)
    );

    always #5 clock = ~clock;

    // Engine model: done rises eng_delay negedges after the launch is seen, held eng_hold cycles.
    always @(negedge clock) begin
        if (reset) begin
            eng_dor = 1'b0;
            e_cnt   = 0;
            e_hold  = 0;
        end else begin
            if (eng_dor) begin
                if (e_hold > 1) e_hold = e_hold - 1;
                else begin
                    eng_dor = 1'b0;
                    e_hold  = 0;
                end
            end else if (e_cnt > 0) begin
                e_cnt = e_cnt - 1;
                if (e_cnt == 0) begin
                    eng_dor   = 1'b1;
                    e_hold    = eng_hold;
                    eng_count = CW'($countones(eng_data));
                end
            end
            if (eng_start && !eng_dead) e_cnt = eng_delay;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(input logic [N-1:0] exp, input logic [W-1:0] word, input string tag);
        int n = 0;
        while (gnt == '0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_gnt"}, 32'(gnt), 32'(exp));
        check({tag, "_start"}, 32'(eng_start), 32'd1);
        check({tag, "_eng_data"}, 32'(eng_data), 32'(word));
        req = req & ~gnt;
        @(negedge clock);
        check({tag, "_gnt_pulse"}, 32'(gnt), 32'd0);
        check({tag, "_start_pulse"}, 32'(eng_start), 32'd0);
    endtask

    task automatic wait_rsp(input logic [N-1:0] exp_v, input logic [CW-1:0] exp_c, input string tag);
        int n = 0;
        while (rsp_valid == '0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(exp_v));
        check({tag, "_rsp_count"}, 32'(rsp_count), 32'(exp_c));
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        @(negedge clock);
        check({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 20) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_count"}, 32'(rsp_count), 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_eng_start"}, 32'(eng_start), 32'd0);
        check({tag, "_eng_data"}, 32'(eng_data), 32'd0);
    endtask

    initial begin
        logic [W-1:0]  words [N];
        logic [CW-1:0] counts[N];
        words  = '{8'h00, 8'hFF, 8'h0F, 8'h81};
        counts = '{4'd0, 4'd8, 4'd4, 4'd2};

        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        repeat (2) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;

        // 1: single request, word 0 = B5 (five ones)
        req_data = {8'h00, 8'h00, 8'h00, 8'hB5};
        req      = 4'b0001;
        wait_gnt(4'b0001, 8'hB5, "t1");
        wait_rsp(4'b0001, 4'd5, "t1");
        check("t1_eng_data_held", 32'(eng_data), 32'hB5);
        wait_idle("t1");

        // 2: all four request after reset, served 0,1,2,3
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset    = 1'b0;
        req_data = {words[3], words[2], words[1], words[0]};
        req      = 4'b1111;
        for (int k = 0; k < N; k++) begin
            wait_gnt(4'b0001 << k, words[k], $sformatf("t2_%0d", k));
            wait_rsp(4'b0001 << k, counts[k], $sformatf("t2_%0d", k));
        end
        wait_idle("t2");

        // 3: serve 2 alone (ptr -> 3), then 0101 grants 0 before 2
        req = 4'b0100;
        wait_gnt(4'b0100, 8'h0F, "t3a");
        wait_rsp(4'b0100, 4'd4, "t3a");
        wait_idle("t3a");
        req = 4'b0101;
        wait_gnt(4'b0001, 8'h00, "t3b");
        wait_rsp(4'b0001, 4'd0, "t3b");
        wait_gnt(4'b0100, 8'h0F, "t3c");
        wait_rsp(4'b0100, 4'd4, "t3c");
        wait_idle("t3");

        // 4: two-cycle done gives one response; a waiting request is granted a cycle after done falls
        req_data[1*W +: W] = 8'h7E;
        req = 4'b0010;
        wait_gnt(4'b0010, 8'h7E, "t4");
        req = 4'b1000;
        wait_rsp(4'b0010, 4'd6, "t4");
        check("t4_drain_gnt", 32'(gnt), 32'd0);
        check("t4_drain_busy", 32'(busy), 32'd1);
        @(negedge clock);
        check("t4_idle_gnt", 32'(gnt), 32'd0);
        check("t4_idle_busy", 32'(busy), 32'd0);
        @(negedge clock);
        check("t4_next_gnt", 32'(gnt), 32'b1000);
        wait_gnt(4'b1000, 8'h81, "t4b");
        wait_rsp(4'b1000, 4'd2, "t4b");
        wait_idle("t4");

        // 5: move ptr to 2, reset in WAIT, then 1010 must grant 1 (ptr back to 0)
        req = 4'b0010;
        wait_gnt(4'b0010, 8'h7E, "t5a");
        wait_rsp(4'b0010, 4'd6, "t5a");
        wait_idle("t5a");
        eng_delay = 10;
        req = 4'b0100;
        wait_gnt(4'b0100, 8'h0F, "t5b");
        @(negedge clock);
        check("t5_busy_in_wait", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_all_zero("t5_reset");
        @(negedge clock);
        @(negedge clock);
        reset     = 1'b0;
        eng_delay = 3;
        req       = 4'b1010;
        wait_gnt(4'b0010, 8'h7E, "t5c");
        wait_rsp(4'b0010, 4'd6, "t5c");
        wait_gnt(4'b1000, 8'h81, "t5d");
        wait_rsp(4'b1000, 4'd2, "t5d");
        wait_idle("t5");

        // 6: engine never completes
        eng_dead = 1'b1;
        req      = 4'b0001;
        wait_gnt(4'b0001, 8'h00, "t6");
`ifdef POPCOUNT_ARB_TIMEOUT_EN
        repeat (11) @(negedge clock);
        check("t6_no_early_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clock);
        check("t6_tmo_valid", 32'(rsp_valid), 32'b0001);
        check("t6_tmo_err", 32'(rsp_err), 32'd1);
        check("t6_tmo_count", 32'(rsp_count), 32'd0);
        @(negedge clock);
        check("t6_tmo_pulse", 32'(rsp_valid), 32'd0);
        check("t6_tmo_idle", 32'(busy), 32'd0);
`else
        repeat (20) @(negedge clock);
        check("t6_busy_stuck", 32'(busy), 32'd1);
        check("t6_no_rsp", 32'(rsp_valid), 32'd0);
        check("t6_err_tied", 32'(rsp_err), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
